// File: rtl/alu_sequencer_if.sv
// Request/response bundle between the control unit and the ALU sequencer.
// The control unit is the master. The sequencer is the slave.
interface alu_sequencer_if #(
    parameter int MAX_BYTES = 4
);
    localparam int W    = 8 * MAX_BYTES;
    localparam int NB_W = $clog2(MAX_BYTES) + 1;

    logic            req_valid;
    logic            req_ready;
    logic [W-1:0]    req_lhs;
    logic [W-1:0]    req_rhs;
    logic [NB_W-1:0] req_nbytes;
    logic [1:0]      req_shift_op;
    logic [1:0]      req_shift_interp;
    logic [3:0]      req_logic_op;
    logic            req_carry_first;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [W-1:0]    rsp_result;
    logic            rsp_carry;

    modport master (
        output req_valid, req_lhs, req_rhs, req_nbytes, req_shift_op,
               req_shift_interp, req_logic_op, req_carry_first, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_carry
    );

    modport slave (
        input  req_valid, req_lhs, req_rhs, req_nbytes, req_shift_op,
               req_shift_interp, req_logic_op, req_carry_first, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_carry
    );
endinterface

// File: rtl/alu_sequencer.sv
// Initiator for the two-stage byte ALU.
// It streams a multi-byte operation LSB first, chains the carry between
// bytes, and assembles the result word for a valid/ready response.
//
// state | meaning
// IDLE  | ready for a request; byte 0 is issued at the accepting edge
// ISSUE | bytes 1..n-1 are issued, one per edge
// DRAIN | all bytes issued; waiting for the last result and carry
// RESP  | response is held until rsp_ready
module alu_sequencer #(
    parameter int MAX_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    alu_sequencer_if.slave bus,
    output logic [7:0]  alu_lhs,
    output logic [7:0]  alu_rhs,
    output logic [1:0]  alu_shift_op,
    output logic [1:0]  alu_shift_interp,
    output logic [3:0]  alu_logic_op,
    output logic [1:0]  alu_carry_sel,
    input  logic [7:0]  alu_result,
    input  logic        alu_carry_out
);
    localparam int W    = 8 * MAX_BYTES;
    localparam int NB_W = $clog2(MAX_BYTES) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t          state, state_nx;
    logic            accept;
    logic [NB_W-1:0] n_req;

    logic [W-1:0]    lhs_sh, rhs_sh;
    logic [NB_W-1:0] rem_q;
    logic [NB_W-1:0] idx_q;
    logic            carry_first_q;
    logic            ready_q;

    // p0: byte currently presented on alu_lhs/alu_rhs.
    // p1: byte whose carry_sel is being presented and whose result is due at the next edge.
    logic            p0_v, p0_first, p0_last;
    logic [NB_W-1:0] p0_idx;
    logic            p1_v, p1_last;
    logic [NB_W-1:0] p1_idx;

    logic [W-1:0]    rsp_result_q;
    logic            rsp_valid_q, rsp_carry_q;

    // req_ready is a registered flag. Reset forces it low while rst is held.
    assign bus.req_ready  = ready_q & ~rst;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;

    // Clamp the byte count. A count of 0 or a count above MAX_BYTES means a full-width operation.
    always_comb begin
        n_req = bus.req_nbytes;
        if (bus.req_nbytes == '0 || bus.req_nbytes > NB_W'(MAX_BYTES))
            n_req = NB_W'(MAX_BYTES);
    end

    // Next-state logic and the acceptance strobe.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) begin
                accept   = 1'b1;
                state_nx = (n_req > NB_W'(1)) ? ISSUE : DRAIN;
            end
            ISSUE: if (rem_q == NB_W'(1)) state_nx = DRAIN;
            DRAIN: if (p1_v && p1_last) state_nx = RESP;
            RESP:  if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Issue the operand bytes, pipeline the carry select, and capture the results.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_lhs          <= '0;
            alu_rhs          <= '0;
            alu_shift_op     <= '0;
            alu_shift_interp <= '0;
            alu_logic_op     <= '0;
            alu_carry_sel    <= '0;
            lhs_sh           <= '0;
            rhs_sh           <= '0;
            rem_q            <= '0;
            idx_q            <= '0;
            carry_first_q    <= 1'b0;
            ready_q          <= 1'b1;
            p0_v             <= 1'b0;
            p0_first         <= 1'b0;
            p0_last          <= 1'b0;
            p0_idx           <= '0;
            p1_v             <= 1'b0;
            p1_last          <= 1'b0;
            p1_idx           <= '0;
            rsp_result_q     <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_carry_q      <= 1'b0;
        end else begin
            ready_q       <= (state_nx == IDLE);
            alu_carry_sel <= !p0_v    ? 2'b00 :
                             p0_first ? {1'b0, carry_first_q} : 2'b10;
            p1_v     <= p0_v;
            p1_last  <= p0_last;
            p1_idx   <= p0_idx;
            p0_v     <= 1'b0;
            p0_first <= 1'b0;
            p0_last  <= 1'b0;

            if (p1_v)
                rsp_result_q[{p1_idx, 3'b000} +: 8] <= alu_result;
            if (p1_v && p1_last) begin
                rsp_carry_q <= alu_carry_out;
                rsp_valid_q <= 1'b1;
            end
            if (state == RESP && bus.rsp_ready)
                rsp_valid_q <= 1'b0;

            if (accept) begin
                alu_lhs          <= bus.req_lhs[7:0];
                alu_rhs          <= bus.req_rhs[7:0];
                alu_shift_op     <= bus.req_shift_op;
                alu_shift_interp <= bus.req_shift_interp;
                alu_logic_op     <= bus.req_logic_op;
                lhs_sh           <= bus.req_lhs >> 8;
                rhs_sh           <= bus.req_rhs >> 8;
                carry_first_q    <= bus.req_carry_first;
                rem_q            <= n_req - NB_W'(1);
                idx_q            <= NB_W'(1);
                p0_v             <= 1'b1;
                p0_first         <= 1'b1;
                p0_last          <= (n_req == NB_W'(1));
                p0_idx           <= '0;
                rsp_result_q     <= '0;
            end else if (state == ISSUE) begin
                alu_lhs <= lhs_sh[7:0];
                alu_rhs <= rhs_sh[7:0];
                lhs_sh  <= lhs_sh >> 8;
                rhs_sh  <= rhs_sh >> 8;
                rem_q   <= rem_q - NB_W'(1);
                idx_q   <= idx_q + NB_W'(1);
                p0_v    <= 1'b1;
                p0_last <= (rem_q == NB_W'(1));
                p0_idx  <= idx_q;
            end else begin
                alu_lhs <= '0;
                alu_rhs <= '0;
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer.
// It contains a two-stage byte ALU model and a word-level reference for the operations.
module tb_alu_sequencer;
    localparam int MB = 4;
    localparam int W  = 8 * MB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] alu_lhs, alu_rhs, alu_result;
    logic [1:0] alu_shift_op, alu_shift_interp, alu_carry_sel;
    logic [3:0] alu_logic_op;
    logic       alu_carry_out;

    int checks = 0;
    int errors = 0;

    alu_sequencer_if #(.MAX_BYTES(MB)) bus ();

    alu_sequencer #(.MAX_BYTES(MB)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_shift_op(alu_shift_op), .alu_shift_interp(alu_shift_interp),
        .alu_logic_op(alu_logic_op), .alu_carry_sel(alu_carry_sel),
        .alu_result(alu_result), .alu_carry_out(alu_carry_out)
    );

    always #5 clk = ~clk;

    // ALU model. Stage 1 registers the shifted LHS and the logic-processed RHS.
    // Stage 2 adds them with the selected carry (00 gives 0, 01 gives 1, 10 gives the previous carry).
    logic [7:0] s1_a, s1_b;
    logic       c_q, cin;

    function automatic logic [7:0] shift_f(input logic [7:0] a, input logic [1:0] op);
        case (op)
            2'b01:   return a << 1;
            2'b10:   return a >> 1;
            2'b11:   return {a[6:0], a[7]};
            default: return a;
        endcase
    endfunction

    // ALU stage 1 register and the carry-chain register.
    always_ff @(posedge clk) begin
        s1_a <= shift_f(alu_lhs, alu_shift_op);
        s1_b <= (alu_logic_op == 4'h1) ? ~alu_rhs : alu_rhs;
        c_q  <= alu_carry_out;
    end

    // ALU stage 2 adder.
    always_comb begin
        cin = 1'b0;
        if (alu_carry_sel == 2'b01) cin = 1'b1;
        else if (alu_carry_sel == 2'b10) cin = c_q;
        {alu_carry_out, alu_result} = {1'b0, s1_a} + {1'b0, s1_b} + {8'd0, cin};
    end

    // Word-level reference: the n-byte sum of LHS and (RHS or ~RHS) plus the carry-in.
    // Bytes at or above n are zero. The carry is the bit just above byte n-1.
    function automatic logic [W:0] ref_op(input logic [W-1:0] lhs, input logic [W-1:0] rhs,
                                          input int n, input logic [3:0] lop, input logic cf);
        logic [W-1:0] mask, b;
        logic [W:0]   sum;
        mask = '0;
        for (int i = 0; i < n; i++) mask[8*i +: 8] = 8'hFF;
        b   = ((lop == 4'h1) ? ~rhs : rhs) & mask;
        sum = {1'b0, lhs & mask} + {1'b0, b} + {{W{1'b0}}, cf};
        return {sum[8*n], sum[W-1:0] & mask};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_valid        = 1'b0;
        bus.req_lhs          = '0;
        bus.req_rhs          = '0;
        bus.req_nbytes       = '0;
        bus.req_shift_op     = 2'b00;
        bus.req_shift_interp = 2'b00;
        bus.req_logic_op     = 4'h0;
        bus.req_carry_first  = 1'b0;
        bus.rsp_ready        = 1'b0;
    endtask

    // One full operation with bp cycles of response backpressure.
    // A second request is offered during the backpressure and must be ignored.
    task automatic run_op(input logic [W-1:0] lhs, input logic [W-1:0] rhs, input logic [2:0] nb,
                          input logic [3:0] lop, input logic cf, input logic [1:0] interp, input int bp);
        int         n;
        logic [W:0] exp;
        n   = (nb == 3'd0 || nb > 3'(MB)) ? MB : int'(nb);
        exp = ref_op(lhs, rhs, n, lop, cf);

        chk("ready_before", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid        = 1'b1;
        bus.req_lhs          = lhs;
        bus.req_rhs          = rhs;
        bus.req_nbytes       = nb;
        bus.req_logic_op     = lop;
        bus.req_shift_interp = interp;
        bus.req_carry_first  = cf;
        tick();
        bus.req_valid = 1'b0;
        chk("lhs_b0", {56'd0, alu_lhs}, {56'd0, lhs[7:0]});
        chk("rhs_b0", {56'd0, alu_rhs}, {56'd0, rhs[7:0]});
        chk("ctl_ops", {56'd0, alu_shift_op, alu_shift_interp, alu_logic_op}, {56'd0, 2'b00, interp, lop});
        chk("ready_busy", {63'd0, bus.req_ready}, 64'd0);

        for (int k = 1; k <= n + 1; k++) begin
            tick();
            if (k < n) begin
                chk("lhs_bk", {56'd0, alu_lhs}, {56'd0, lhs[8*k +: 8]});
                chk("rhs_bk", {56'd0, alu_rhs}, {56'd0, rhs[8*k +: 8]});
            end else begin
                chk("lhs_idle", {48'd0, alu_lhs, alu_rhs}, 64'd0);
            end
            if (k <= n)
                chk("carry_sel", {62'd0, alu_carry_sel}, (k == 1) ? {63'd0, cf} : 64'd2);
            else
                chk("carry_sel_end", {62'd0, alu_carry_sel}, 64'd0);
            chk("rsp_valid_lat", {63'd0, bus.rsp_valid}, (k == n + 1) ? 64'd1 : 64'd0);
        end
        chk("rsp_result", {32'd0, bus.rsp_result}, {32'd0, exp[W-1:0]});
        chk("rsp_carry", {63'd0, bus.rsp_carry}, {63'd0, exp[W]});

        for (int j = 0; j < bp; j++) begin
            bus.req_valid = 1'b1;
            bus.req_lhs   = ~lhs;
            tick();
            chk("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
            chk("bp_result", {31'd0, bus.rsp_carry, bus.rsp_result}, {31'd0, exp});
            chk("bp_ready", {63'd0, bus.req_ready}, 64'd0);
            chk("bp_no_issue", {48'd0, alu_lhs, alu_rhs}, 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_drop", {63'd0, bus.rsp_valid}, 64'd0);
        chk("ready_after", {63'd0, bus.req_ready}, 64'd1);
    endtask

    initial begin
        int seen;
        idle_inputs();

        // Reset
        repeat (3) tick();
        chk("rst_ready", {63'd0, bus.req_ready}, 64'd0);
        chk("rst_alu", {42'd0, alu_lhs, alu_rhs, alu_shift_op, alu_shift_interp, alu_logic_op, alu_carry_sel}, 64'd0);
        chk("rst_rsp", {30'd0, bus.rsp_valid, bus.rsp_carry, bus.rsp_result}, 64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, bus.req_ready}, 64'd1);
        tick();

        // Directed operations
        run_op(32'h0000005A, 32'h00000033, 3'd1, 4'h0, 1'b0, 2'b00, 0);
        run_op(32'hFFFFFFFF, 32'h00000001, 3'd4, 4'h0, 1'b0, 2'b01, 1);
        run_op(32'h00001234, 32'h00000235, 3'd2, 4'h1, 1'b1, 2'b10, 5);
        run_op(32'hDEADBEEF, 32'h01234567, 3'd0, 4'h0, 1'b1, 2'b11, 0);
        run_op(32'h80000000, 32'h80000000, 3'd7, 4'h0, 1'b0, 2'b00, 2);

        // Reset in the middle of an n=4 operation, asserted at edge A+2
        bus.req_valid  = 1'b1;
        bus.req_lhs    = 32'hA5A5A5A5;
        bus.req_rhs    = 32'h5A5A5A5A;
        bus.req_nbytes = 3'd4;
        tick();
        bus.req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_alu", {42'd0, alu_lhs, alu_rhs, alu_shift_op, alu_shift_interp, alu_logic_op, alu_carry_sel}, 64'd0);
        chk("midrst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("midrst_ready_low", {63'd0, bus.req_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("midrst_ready", {63'd0, bus.req_ready}, 64'd1);
        seen = 0;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.rsp_valid) seen++;
        end
        bus.rsp_ready = 1'b0;
        chk("midrst_no_rsp", 64'(seen), 64'd0);

        // Randomised operations
        for (int t = 0; t < 24; t++) begin
            run_op($urandom, $urandom, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
